reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Register file and write-scoreboard that sits at the receiving end of the write-back stage.
- Holds R0–R7, 16 bits each; R7 is the PC.
- Accepts one write-back per cycle.
- Serves two combinational read ports to decode/register-read with write-through bypass.
- Tracks outstanding writes per register so the read stage can detect RAW hazards and stall.

Parameters:
NUM_REGS, 8, number of architectural registers (address width = 3)
DATA_W, 16, register width
PEND_W, 2, width of per-register outstanding-write counter (max 3 in flight)
PC_IDX, 7, index of register aliased as PC

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
wb_data  input  16  write-back data
wb_addr  input  3  write-back destination register
rwbar  input  1  write-back strobe; 0 = write, 1 = no write
ra_addr  input  3  read port A address
rb_addr  input  3  read port B address
rd_a  output  16  read port A data
rd_b  output  16  read port B data
hazard_a  output  1  port A register has an unresolved pending write
hazard_b  output  1  port B register has an unresolved pending write
issue_valid  input  1  an instruction with a register destination is issuing
issue_addr  input  3  destination of issuing instruction
issue_stall  output  1  issue rejected because counter for issue_addr is saturated
pc_we  input  1  fetch-side PC update enable
pc_next  input  16  next PC value
pc_out  output  16  current R7 value
wb_underflow  output  1  sticky error: write-back to a register with zero pending count

Behaviour:
- Reset:
  - Interface: one clock, clk. Reset is synchronous and active-high, port reset.
  - On a clk edge with reset=1: all registers, all pending counters and wb_underflow go to 0.
  - Same-cycle write-back, issue and pc_we are ignored.
  - Outputs after reset: rd_a/rd_b = 0, pc_out = 0, hazard_a/hazard_b = 0, issue_stall = 0.
- Write:
  - When rwbar=0, regs[wb_addr] <= wb_data at the edge.
  - Write latency to storage is 1 cycle.
- Read bypass:
  - rd_a = wb_data when rwbar=0 and wb_addr==ra_addr; otherwise rd_a = regs[ra_addr]. rd_b likewise.
  - Reads are combinational, 0-cycle latency.
- PC:
  - When pc_we=1, R7 <= pc_next.
  - If rwbar=0 and wb_addr==7 in the same cycle, the write-back wins and pc_next is dropped.
  - pc_out = regs[7], registered value with no bypass.
- Pending counters, cnt[i], PEND_W bits:
  - inc = issue accepted to i. An issue is accepted when issue_valid=1 and issue_stall=0.
  - dec = rwbar=0 and wb_addr==i.
  - inc and dec together: unchanged.
  - inc only: +1.
  - dec only: −1 if cnt>0. If cnt==0, counter stays 0 and wb_underflow <= 1 (sticky until reset). The write data is still committed.
- issue_stall:
  - Combinational: issue_valid=1 and cnt[issue_addr]==3 and not (rwbar=0 and wb_addr==issue_addr).
  - A stalled issue does not modify any counter.
- hazard_a:
  - Asserted when cnt[ra_addr]!=0, except when cnt[ra_addr]==1 and the same-cycle write-back targets ra_addr; the bypass resolves that case.
  - hazard_b is analogous.
- No state machine beyond the counters. All state updates happen on the rising edge of clk only.

Decomposition:
- Shared package (risc_pkg): REG_ADDR_W=3, DATA_W=16, PC_IDX=7, and the rwbar write/idle encoding constants.
- Natural sub-module: pend_counter, one per register. It takes inc/dec/clear and outputs count, saturated and underflow.
- Storage, bypass and PC arbitration stay in reg_file_sb.

Test Plan:
- Reset, then rwbar=0, wb_addr=3, wb_data=16'hBEEF with ra_addr=3 -> rd_a=BEEF in the same cycle; next cycle rwbar=1 -> rd_a=BEEF from storage.
- pc_we=1, pc_next=16'h0010 together with rwbar=0, wb_addr=7, wb_data=16'h0200 -> pc_out=0200 next cycle; then pc_we=1, pc_next=0202 alone -> pc_out=0202.
- Hazard tracking:
  - Issue to r2 four times -> cnt=3 after three issues; fourth cycle issue_stall=1 and cnt stays 3.
  - ra_addr=2 -> hazard_a=1.
  - Three write-backs to r2 -> hazard_a drops in the cycle of the third write, via bypass.
- Issue to r5 and write-back to r5 in the same cycle with cnt[5]=1 -> cnt[5] stays 1, hazard_b=1 for rb_addr=5.
- Write-back to r4 with cnt[4]=0 -> wb_underflow=1 next cycle and remains 1; regs[4] is updated. Asserting reset clears it to 0.
- Load r1=16'h1234 and set cnt[1]=2, then assert reset for one cycle while rwbar=0, wb_addr=1 -> regs[1]=0, cnt[1]=0, hazard_a=0 for ra_addr=1.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the register file / write scoreboard.
package reg_file_sb_pkg;

  localparam int NUM_REGS   = 8;
  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int PEND_W     = 2;
  localparam int PC_IDX     = 7;

  localparam logic RWBAR_WRITE = 1'b0;
  localparam logic RWBAR_IDLE  = 1'b1;

  localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [PEND_W-1:0]     pend_t;

  function automatic logic wb_hits(input logic rwbar, input reg_addr_t wb_addr, input reg_addr_t addr);
    return (rwbar == RWBAR_WRITE) && (wb_addr == addr);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Write-back, read, issue and PC signals between pipeline stages and the register file.
interface reg_file_sb_if;
  import reg_file_sb_pkg::*;

  data_t     wb_data;
  reg_addr_t wb_addr;
  logic      rwbar;
  reg_addr_t ra_addr;
  reg_addr_t rb_addr;
  data_t     rd_a;
  data_t     rd_b;
  logic      hazard_a;
  logic      hazard_b;
  logic      issue_valid;
  reg_addr_t issue_addr;
  logic      issue_stall;
  logic      pc_we;
  data_t     pc_next;
  data_t     pc_out;
  logic      wb_underflow;

  modport master (
    output wb_data, wb_addr, rwbar, ra_addr, rb_addr, issue_valid, issue_addr, pc_we, pc_next,
    input  rd_a, rd_b, hazard_a, hazard_b, issue_stall, pc_out, wb_underflow
  );

  modport slave (
    input  wb_data, wb_addr, rwbar, ra_addr, rb_addr, issue_valid, issue_addr, pc_we, pc_next,
    output rd_a, rd_b, hazard_a, hazard_b, issue_stall, pc_out, wb_underflow
  );
endinterface

// File: rtl/reg_file_sb_pend_counter.sv
// Per-register outstanding-write counter; saturates at PEND_MAX, floors at zero.
module pend_counter
  import reg_file_sb_pkg::*;
(
  input  logic  clk,
  input  logic  i_clear,
  input  logic  i_inc,
  input  logic  i_dec,
  output pend_t o_count,
  output logic  o_saturated,
  output logic  o_underflow
);

  pend_t r_count;

  // Count update: simultaneous inc/dec cancel; dec at zero holds zero.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   r_count <= (r_count == PEND_MAX) ? r_count : r_count + 2'd1;
        2'b01:   r_count <= (r_count == 2'd0) ? r_count : r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_saturated = (r_count == PEND_MAX);
  assign o_underflow = i_dec && !i_inc && (r_count == 2'd0);

endmodule

// File: rtl/reg_file_sb.sv
// R0-R7 register file (R7 = PC) with write-through read bypass and RAW scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  reg_file_sb_if.slave  bus
);

  data_t r_regs [NUM_REGS];
  logic  r_underflow;

  pend_t w_cnt   [NUM_REGS];
  logic  [NUM_REGS-1:0] w_sat;
  logic  [NUM_REGS-1:0] w_uf;
  logic  [NUM_REGS-1:0] w_inc;
  logic  [NUM_REGS-1:0] w_dec;
  logic  w_issue_stall;

  // A saturated destination stalls unless this cycle's write-back frees a slot.
  assign w_issue_stall = bus.issue_valid && w_sat[bus.issue_addr]
                         && !wb_hits(bus.rwbar, bus.wb_addr, bus.issue_addr);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    assign w_inc[g] = bus.issue_valid && !w_issue_stall && (bus.issue_addr == reg_addr_t'(g));
    assign w_dec[g] = wb_hits(bus.rwbar, bus.wb_addr, reg_addr_t'(g));

    pend_counter u_cnt (
      .clk         (clk),
      .i_clear     (reset),
      .i_inc       (w_inc[g]),
      .i_dec       (w_dec[g]),
      .o_count     (w_cnt[g]),
      .o_saturated (w_sat[g]),
      .o_underflow (w_uf[g])
    );
  end

  // Storage update; a write-back to the PC register overrides the fetch-side update.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        r_regs[i] <= '0;
      end else if (w_dec[i]) begin
        r_regs[i] <= bus.wb_data;
      end else if ((i == PC_IDX) && bus.pc_we) begin
        r_regs[i] <= bus.pc_next;
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  // Sticky flag for a write-back that found no outstanding issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= r_underflow | (|w_uf);
    end
  end

  // Read ports with bypass and hazard detection; a single pending write retired now is no hazard.
  always_comb begin
    bus.rd_a     = wb_hits(bus.rwbar, bus.wb_addr, bus.ra_addr) ? bus.wb_data : r_regs[bus.ra_addr];
    bus.rd_b     = wb_hits(bus.rwbar, bus.wb_addr, bus.rb_addr) ? bus.wb_data : r_regs[bus.rb_addr];
    bus.hazard_a = (w_cnt[bus.ra_addr] != 2'd0)
                   && !((w_cnt[bus.ra_addr] == 2'd1) && wb_hits(bus.rwbar, bus.wb_addr, bus.ra_addr));
    bus.hazard_b = (w_cnt[bus.rb_addr] != 2'd0)
                   && !((w_cnt[bus.rb_addr] == 2'd1) && wb_hits(bus.rwbar, bus.wb_addr, bus.rb_addr));
  end

  assign bus.issue_stall  = w_issue_stall;
  assign bus.pc_out       = r_regs[PC_IDX];
  assign bus.wb_underflow = r_underflow;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, PC arbitration, scoreboard, underflow and reset.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  reg_file_sb_if bus ();

  reg_file_sb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rwbar       = RWBAR_IDLE;
    bus.wb_addr     = 3'd0;
    bus.wb_data     = 16'h0000;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = 3'd0;
    bus.pc_we       = 1'b0;
    bus.pc_next     = 16'h0000;
  endtask

  task automatic wb(input logic [2:0] addr, input logic [15:0] data);
    bus.rwbar   = RWBAR_WRITE;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    bus.ra_addr = 3'd0;
    bus.rb_addr = 3'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_rd_a", bus.rd_a, 16'h0000);
    check("rst_rd_b", bus.rd_b, 16'h0000);
    check("rst_pc_out", bus.pc_out, 16'h0000);
    check("rst_hazard_a", 16'(bus.hazard_a), 16'h0000);
    check("rst_hazard_b", 16'(bus.hazard_b), 16'h0000);
    check("rst_issue_stall", 16'(bus.issue_stall), 16'h0000);
    check("rst_underflow", 16'(bus.wb_underflow), 16'h0000);

    // Bypass then storage read of r3 (cnt[3]=0, so this also underflows).
    bus.ra_addr = 3'd3;
    wb(3'd3, 16'hBEEF);
    #1;
    check("bypass_rd_a", bus.rd_a, 16'hBEEF);
    tick();
    idle_inputs();
    #1;
    check("stored_rd_a", bus.rd_a, 16'hBEEF);
    check("r3_underflow", 16'(bus.wb_underflow), 16'h0001);

    // Write-back to R7 beats pc_next; pc_out has no bypass.
    wb(3'd7, 16'h0200);
    bus.pc_we   = 1'b1;
    bus.pc_next = 16'h0010;
    #1;
    check("pc_no_bypass", bus.pc_out, 16'h0000);
    tick();
    idle_inputs();
    bus.pc_we   = 1'b1;
    bus.pc_next = 16'h0202;
    #1;
    check("pc_wb_wins", bus.pc_out, 16'h0200);
    tick();
    idle_inputs();
    #1;
    check("pc_we_alone", bus.pc_out, 16'h0202);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst2_underflow", 16'(bus.wb_underflow), 16'h0000);
    check("rst2_pc_out", bus.pc_out, 16'h0000);
    check("rst2_rd_a", bus.rd_a, 16'h0000);

    // Fill r2 scoreboard to saturation.
    bus.ra_addr     = 3'd2;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd2;
    #1;
    check("r2_cnt0_stall", 16'(bus.issue_stall), 16'h0000);
    check("r2_cnt0_hazard", 16'(bus.hazard_a), 16'h0000);
    tick();
    check("r2_cnt1_hazard", 16'(bus.hazard_a), 16'h0001);
    tick();
    tick();
    check("r2_cnt3_stall", 16'(bus.issue_stall), 16'h0001);
    check("r2_cnt3_hazard", 16'(bus.hazard_a), 16'h0001);
    tick();
    check("r2_still_stall", 16'(bus.issue_stall), 16'h0001);

    // Issue plus write-back at saturation: accepted, count stays 3.
    wb(3'd2, 16'h1111);
    #1;
    check("r2_sat_wb_no_stall", 16'(bus.issue_stall), 16'h0000);
    check("r2_wb1_hazard", 16'(bus.hazard_a), 16'h0001);
    check("r2_wb1_rd_a", bus.rd_a, 16'h1111);
    tick();
    bus.issue_valid = 1'b0;
    wb(3'd2, 16'h2222);
    #1;
    check("r2_wb2_hazard", 16'(bus.hazard_a), 16'h0001);
    tick();
    wb(3'd2, 16'h3333);
    #1;
    check("r2_wb3_hazard", 16'(bus.hazard_a), 16'h0001);
    tick();
    wb(3'd2, 16'h4444);
    #1;
    check("r2_wb4_bypass_clear", 16'(bus.hazard_a), 16'h0000);
    check("r2_wb4_rd_a", bus.rd_a, 16'h4444);
    tick();
    idle_inputs();
    #1;
    check("r2_drained_hazard", 16'(bus.hazard_a), 16'h0000);
    check("r2_drained_rd_a", bus.rd_a, 16'h4444);
    check("r2_no_underflow", 16'(bus.wb_underflow), 16'h0000);

    // r5: issue and write-back together with cnt=1 leaves cnt at 1.
    bus.rb_addr     = 3'd5;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd5;
    tick();
    check("r5_cnt1_hazard", 16'(bus.hazard_b), 16'h0001);
    wb(3'd5, 16'h5555);
    #1;
    check("r5_same_cycle_hazard", 16'(bus.hazard_b), 16'h0000);
    tick();
    idle_inputs();
    #1;
    check("r5_cnt_held_hazard", 16'(bus.hazard_b), 16'h0001);
    check("r5_rd_b", bus.rd_b, 16'h5555);
    wb(3'd5, 16'h5556);
    tick();
    idle_inputs();
    #1;
    check("r5_drained_hazard", 16'(bus.hazard_b), 16'h0000);
    check("r5_no_underflow", 16'(bus.wb_underflow), 16'h0000);

    // r4 write-back with nothing pending: sticky underflow, data committed.
    bus.ra_addr = 3'd4;
    wb(3'd4, 16'h4A4A);
    #1;
    check("r4_uf_before_edge", 16'(bus.wb_underflow), 16'h0000);
    tick();
    idle_inputs();
    #1;
    check("r4_underflow", 16'(bus.wb_underflow), 16'h0001);
    check("r4_data", bus.rd_a, 16'h4A4A);
    tick();
    check("r4_underflow_sticky", 16'(bus.wb_underflow), 16'h0001);

    // r1: load 1234 with cnt=2, then reset overrides a same-cycle write-back.
    bus.ra_addr     = 3'd1;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd1;
    tick();
    tick();
    wb(3'd1, 16'h1234);
    tick();
    idle_inputs();
    #1;
    check("r1_loaded", bus.rd_a, 16'h1234);
    check("r1_hazard", 16'(bus.hazard_a), 16'h0001);
    reset = 1'b1;
    wb(3'd1, 16'hFFFF);
    bus.pc_we       = 1'b1;
    bus.pc_next     = 16'h7777;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd1;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    check("r1_rst_data", bus.rd_a, 16'h0000);
    check("r1_rst_hazard", 16'(bus.hazard_a), 16'h0000);
    check("r1_rst_underflow", 16'(bus.wb_underflow), 16'h0000);
    check("r1_rst_pc_out", bus.pc_out, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
